// File: rtl/pipelined_tree_adder_pkg.sv
// Shared helpers for the pipelined tree adder: output width and lane extension.
package pipelined_tree_adder_pkg;

  function automatic int tree_out_w(input int n, input int dw, input int acc_w);
    return dw + n + acc_w;
  endfunction

  // Fill bit used when widening a value: the MSB for signed lanes, zero otherwise.
  function automatic logic ext_fill(input logic msb, input bit is_signed);
    return is_signed ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/pipelined_tree_adder_level.sv
// One registered level of the adder tree: adds adjacent operand pairs losslessly.
module tree_adder_level
  import pipelined_tree_adder_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [LANES*W-1:0]             in_data,
  output logic [(LANES/2)*(W+1)-1:0]     out_sum,
  output logic                           out_valid,
  output logic                           out_last
);

  logic [(LANES/2)*(W+1)-1:0] sum_c;
  logic [W-1:0]               op_a;
  logic [W-1:0]               op_b;

  // Each operand gains one extension bit, so the pair sum can never overflow.
  always_comb begin
    sum_c = '0;
    op_a  = '0;
    op_b  = '0;
    for (int i = 0; i < LANES/2; i++) begin
      op_a = in_data[(2*i)*W +: W];
      op_b = in_data[(2*i+1)*W +: W];
      sum_c[i*(W+1) +: W+1] = {ext_fill(op_a[W-1], SIGNED != 0), op_a}
                            + {ext_fill(op_b[W-1], SIGNED != 0), op_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_sum   <= sum_c;
      out_valid <= in_valid;
      out_last  <= in_last;
    end
  end

endmodule

// File: rtl/pipelined_tree_adder.sv
// Balanced, fully registered adder tree over 2**N lanes with valid/ready
// flow control and an optional per-packet accumulator on the output stage.
module pipelined_tree_adder
  import pipelined_tree_adder_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int DW     = 8,
  parameter  int SIGNED = 0,
  parameter  int ACC_EN = 0,
  parameter  int ACC_W  = 4,
  localparam int OW     = tree_out_w(N, DW, ACC_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [(2**N)*DW-1:0]  in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_data,
  output logic                  out_last,
  output logic                  out_ovf
);

  // Bit offset of stage l inside the flattened bus; stage 0 is the raw input.
  function automatic int stage_off(input int l);
    int o;
    o = 0;
    for (int j = 0; j < l; j++) o += (2**(N-j)) * (DW+j);
    return o;
  endfunction

  localparam int TOTAL = stage_off(N) + DW + N;

  logic [TOTAL-1:0] bus;
  logic [N:0]       vld;
  logic [N:0]       lst;
  logic             en;
  logic [DW+N-1:0]  tree;
  logic [OW-1:0]    tree_ext;

  // One global enable: the whole pipe stalls together, bubbles included.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign bus[(2**N)*DW-1:0] = in_data;
  assign vld[0]             = in_valid;
  assign lst[0]             = in_last;

  for (genvar l = 0; l < N; l++) begin : g_level
    tree_adder_level #(
      .LANES  (2**(N-l)),
      .W      (DW+l),
      .SIGNED (SIGNED)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (vld[l]),
      .in_last   (lst[l]),
      .in_data   (bus[stage_off(l) +: (2**(N-l))*(DW+l)]),
      .out_sum   (bus[stage_off(l+1) +: (2**(N-l-1))*(DW+l+1)]),
      .out_valid (vld[l+1]),
      .out_last  (lst[l+1])
    );
  end

  assign tree = bus[stage_off(N) +: DW+N];

  if (ACC_W == 0) begin : g_ext_none
    assign tree_ext = tree;
  end else begin : g_ext
    assign tree_ext = {{ACC_W{ext_fill(tree[DW+N-1], SIGNED != 0)}}, tree};
  end

  if (ACC_EN == 0) begin : g_direct
    assign out_ovf = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
      end else if (en) begin
        out_valid <= vld[N];
        if (vld[N]) begin
          out_data <= tree_ext;
          out_last <= lst[N];
        end
      end
    end
  end else begin : g_accum
    logic [OW-1:0] acc;
    logic          acc_ovf;
    logic [OW:0]   s_full;
    logic          ovf_step;

    // One guard bit above OW exposes overflow for both signed and unsigned sums.
    assign s_full   = {ext_fill(acc[OW-1], SIGNED != 0), acc}
                    + {ext_fill(tree_ext[OW-1], SIGNED != 0), tree_ext};
    assign ovf_step = (SIGNED != 0) ? (s_full[OW] ^ s_full[OW-1]) : s_full[OW];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
        out_ovf   <= 1'b0;
        acc       <= '0;
        acc_ovf   <= 1'b0;
      end else if (en) begin
        if (vld[N] && lst[N]) begin
          out_data  <= s_full[OW-1:0];
          out_ovf   <= acc_ovf | ovf_step;
          out_last  <= 1'b1;
          out_valid <= 1'b1;
          acc       <= '0;
          acc_ovf   <= 1'b0;
        end else if (vld[N]) begin
          acc       <= s_full[OW-1:0];
          acc_ovf   <= acc_ovf | ovf_step;
          out_valid <= 1'b0;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// Directed bench for pipelined_tree_adder across five parameter sets.
module tb_pipelined_tree_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // A: N=2 unsigned, OW=14
  logic a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last, a_out_ovf;
  logic [31:0] a_in_data;
  logic [13:0] a_out_data;
  // B: N=4 unsigned, OW=16
  logic b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last, b_out_ovf;
  logic [127:0] b_in_data;
  logic [15:0]  b_out_data;
  // C: N=4 signed, OW=16
  logic c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_last, c_out_ovf;
  logic [127:0] c_in_data;
  logic [15:0]  c_out_data;
  // D: N=4 accumulate, ACC_W=4, OW=16
  logic d_in_valid, d_in_ready, d_in_last, d_out_valid, d_out_ready, d_out_last, d_out_ovf;
  logic [127:0] d_in_data;
  logic [15:0]  d_out_data;
  // E: N=4 accumulate, ACC_W=0, OW=12
  logic e_in_valid, e_in_ready, e_in_last, e_out_valid, e_out_ready, e_out_last, e_out_ovf;
  logic [127:0] e_in_data;
  logic [11:0]  e_out_data;

  pipelined_tree_adder #(.N(2), .DW(8), .SIGNED(0), .ACC_EN(0), .ACC_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .out_ovf(a_out_ovf));

  pipelined_tree_adder #(.N(4), .DW(8), .SIGNED(0), .ACC_EN(0), .ACC_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .out_ovf(b_out_ovf));

  pipelined_tree_adder #(.N(4), .DW(8), .SIGNED(1), .ACC_EN(0), .ACC_W(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_last(c_out_last), .out_ovf(c_out_ovf));

  pipelined_tree_adder #(.N(4), .DW(8), .SIGNED(0), .ACC_EN(1), .ACC_W(4)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .in_last(d_in_last), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_last(d_out_last), .out_ovf(d_out_ovf));

  pipelined_tree_adder #(.N(4), .DW(8), .SIGNED(0), .ACC_EN(1), .ACC_W(0)) u_e (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data),
    .in_last(e_in_last), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_data(e_out_data), .out_last(e_out_last), .out_ovf(e_out_ovf));

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out_last, a_out_ovf, a_out_data, a_in_ready} !== {3'b000, 14'd0, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL reset_a: got v=%0b l=%0b o=%0b d=%0d rdy=%0b, expected 0 0 0 0 1",
               a_out_valid, a_out_last, a_out_ovf, a_out_data, a_in_ready);
    end
    n_cmp++;
    if ({d_out_valid, d_out_last, d_out_ovf, d_out_data, d_in_ready} !== {3'b000, 16'd0, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL reset_d: got v=%0b l=%0b o=%0b d=%0d rdy=%0b, expected 0 0 0 0 1",
               d_out_valid, d_out_last, d_out_ovf, d_out_data, d_in_ready);
    end
    n_cmp++;
    if ({e_out_valid, e_out_last, e_out_ovf, e_out_data} !== {3'b000, 12'd0}) begin
      n_bad++;
      $display("[TB] FAIL reset_e: got v=%0b l=%0b o=%0b d=%0d, expected 0 0 0 0",
               e_out_valid, e_out_last, e_out_ovf, e_out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = {8'd4, 8'd3, 8'd2, 8'd1}; a_in_last = 1'b1;
    @(negedge clk);
    a_in_data = {8'd40, 8'd30, 8'd20, 8'd10}; a_in_last = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_early: got out_valid=%0b, expected 0", a_out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out_last, a_out_data} !== {1'b1, 1'b1, 14'd10}) begin
      n_bad++;
      $display("[TB] FAIL basic_sum0: got v=%0b l=%0b d=%0d, expected 1 1 10",
               a_out_valid, a_out_last, a_out_data);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out_last, a_out_data} !== {1'b1, 1'b0, 14'd100}) begin
      n_bad++;
      $display("[TB] FAIL basic_sum1: got v=%0b l=%0b d=%0d, expected 1 0 100",
               a_out_valid, a_out_last, a_out_data);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_drain: got out_valid=%0b, expected 0", a_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int last_c = -1;
    int cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (b_out_valid === 1'b1) begin
        cnt++;
        if (first < 0) first = cyc;
        last_c = cyc;
        n_cmp++;
        if (b_out_data !== 16'd4080) begin
          n_bad++;
          $display("[TB] FAIL b2b_data: cycle %0d got %0d, expected 4080", cyc, b_out_data);
        end
      end
      b_in_valid = (cyc < 8);
      b_in_data  = '1;
      b_in_last  = (cyc == 7);
    end
    b_in_valid = 1'b0;
    n_cmp++;
    if (cnt != 8) begin
      n_bad++;
      $display("[TB] FAIL b2b_count: got %0d outputs, expected 8", cnt);
    end
    n_cmp++;
    if (first != 5) begin
      n_bad++;
      $display("[TB] FAIL b2b_latency: first output at cycle %0d, expected 5", first);
    end
    n_cmp++;
    if (last_c - first != 7) begin
      n_bad++;
      $display("[TB] FAIL b2b_gaps: output span %0d cycles, expected 7", last_c - first);
    end
  endtask

  task automatic test_signed();
    logic [15:0] got [4];
    int cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (c_out_valid === 1'b1) begin
        if (cnt < 4) got[cnt] = c_out_data;
        cnt++;
      end
      c_in_valid = (cyc < 2);
      c_in_data  = (cyc == 0) ? {16{8'h80}} : {16{8'hFF}};
      c_in_last  = 1'b1;
    end
    c_in_valid = 1'b0;
    n_cmp++;
    if (cnt != 2) begin
      n_bad++;
      $display("[TB] FAIL signed_count: got %0d outputs, expected 2", cnt);
    end else begin
      n_cmp++;
      if (got[0] !== 16'hF800) begin
        n_bad++;
        $display("[TB] FAIL signed_min: got %h, expected f800 (-2048)", got[0]);
      end
      n_cmp++;
      if (got[1] !== 16'hFFF0) begin
        n_bad++;
        $display("[TB] FAIL signed_neg1: got %h, expected fff0 (-16)", got[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_q [$];
    logic [15:0] hold;
    logic [15:0] ev;
    logic [7:0]  lane;
    int sent = 0;
    int recv = 0;
    hold = '0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      b_out_ready = !(cyc >= 10 && cyc < 15);
      b_in_valid  = (sent < 10);
      lane        = 8'(sent + 1);
      b_in_data   = {16{lane}};
      b_in_last   = (sent == 9);
      #1;
      if (cyc >= 10 && cyc < 15) begin
        n_cmp++;
        if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL bp_stall: cycle %0d got in_ready=%0b out_valid=%0b, expected 0 1",
                   cyc, b_in_ready, b_out_valid);
        end
        if (cyc == 10) hold = b_out_data;
        else begin
          n_cmp++;
          if (b_out_data !== hold) begin
            n_bad++;
            $display("[TB] FAIL bp_stable: cycle %0d got %0d, expected %0d", cyc, b_out_data, hold);
          end
        end
      end
      if (b_in_valid && b_in_ready) begin
        exp_q.push_back(16'(16 * (sent + 1)));
        sent++;
      end
      if (b_out_valid && b_out_ready) begin
        recv++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL bp_extra: got unexpected output %0d, expected none", b_out_data);
        end else begin
          ev = exp_q.pop_front();
          if (b_out_data !== ev) begin
            n_bad++;
            $display("[TB] FAIL bp_order: got %0d, expected %0d", b_out_data, ev);
          end
        end
      end
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    n_cmp++;
    if (recv != 10 || exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL bp_count: got %0d outputs with %0d pending, expected 10 and 0",
               recv, exp_q.size());
    end
  endtask

  task automatic test_accumulate();
    logic [15:0] got_d;
    logic        got_o;
    logic        got_l;
    int cnt = 0;
    got_d = '0; got_o = 1'b0; got_l = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (d_out_valid === 1'b1) begin
        cnt++;
        got_d = d_out_data; got_o = d_out_ovf; got_l = d_out_last;
      end
      d_in_valid = (cyc < 3);
      d_in_data  = '1;
      d_in_last  = (cyc == 2);
    end
    d_in_valid = 1'b0;
    n_cmp++;
    if (cnt != 1) begin
      n_bad++;
      $display("[TB] FAIL acc_count: got %0d outputs, expected 1", cnt);
    end
    n_cmp++;
    if ({got_d, got_o, got_l} !== {16'd12240, 1'b0, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL acc_sum: got d=%0d ovf=%0b last=%0b, expected 12240 0 1", got_d, got_o, got_l);
    end
  endtask

  task automatic test_acc_overflow();
    logic [11:0] got_d [4];
    logic        got_o [4];
    int cnt = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (e_out_valid === 1'b1) begin
        if (cnt < 4) begin
          got_d[cnt] = e_out_data;
          got_o[cnt] = e_out_ovf;
        end
        cnt++;
      end
      e_in_valid = (cyc < 3);
      e_in_data  = (cyc < 2) ? '1 : {16{8'd1}};
      e_in_last  = (cyc != 0);
    end
    e_in_valid = 1'b0;
    n_cmp++;
    if (cnt != 2) begin
      n_bad++;
      $display("[TB] FAIL ovf_count: got %0d outputs, expected 2", cnt);
    end else begin
      n_cmp++;
      if ({got_d[0], got_o[0]} !== {12'd4064, 1'b1}) begin
        n_bad++;
        $display("[TB] FAIL ovf_wrap: got d=%0d ovf=%0b, expected 4064 1", got_d[0], got_o[0]);
      end
      n_cmp++;
      if ({got_d[1], got_o[1]} !== {12'd16, 1'b0}) begin
        n_bad++;
        $display("[TB] FAIL ovf_clean: got d=%0d ovf=%0b, expected 16 0", got_d[1], got_o[1]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] got_d;
    logic        got_o;
    int cnt = 0;
    got_d = '0; got_o = 1'b0;
    @(negedge clk);
    d_in_valid = 1'b1; d_in_data = '1; d_in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    d_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({d_out_valid, d_out_last, d_out_ovf, d_out_data} !== {3'b000, 16'd0}) begin
      n_bad++;
      $display("[TB] FAIL midrst_clear: got v=%0b l=%0b o=%0b d=%0d, expected 0 0 0 0",
               d_out_valid, d_out_last, d_out_ovf, d_out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (d_out_valid === 1'b1) begin
        cnt++;
        got_d = d_out_data; got_o = d_out_ovf;
      end
      d_in_valid = (cyc == 0);
      d_in_data  = {16{8'd2}};
      d_in_last  = 1'b1;
    end
    d_in_valid = 1'b0;
    n_cmp++;
    if (cnt != 1 || got_d !== 16'd32 || got_o !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midrst_fresh: got %0d outputs, d=%0d ovf=%0b, expected 1 output 32 0",
               cnt, got_d, got_o);
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_data = '0; d_in_last = 1'b0; d_out_ready = 1'b1;
    e_in_valid = 1'b0; e_in_data = '0; e_in_last = 1'b0; e_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_signed();
    test_backpressure();
    test_accumulate();
    test_acc_overflow();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
